// File: rtl/fetch_sequencer_param_if.sv
// Trigger/handshake bundle between the fetch sequencer and the instruction path.
//   run, mem_ready, last_word      : control inputs to the sequencer
//   latch/update_pc/out_latch      : single-bit phase triggers
//   fetch_trigger, decode_trigger  : one-hot per instruction word
//   mem_sel, demux_sel             : address mux / decode demux selects
//   busy, fetch_error              : status
// modport master = sequencer side (drives triggers), slave = datapath side.
interface fetch_sequencer_param_if #(
  parameter int NUM_WORDS = 2
);
  localparam int SEL_W = $clog2((NUM_WORDS > 2) ? NUM_WORDS : 2);

  logic                 run;
  logic                 mem_ready;
  logic                 last_word;
  logic                 latch_trigger;
  logic                 update_pc_trigger;
  logic [NUM_WORDS-1:0] fetch_trigger;
  logic [NUM_WORDS-1:0] decode_trigger;
  logic                 out_latch_trigger;
  logic [SEL_W-1:0]     mem_sel;
  logic [SEL_W-1:0]     demux_sel;
  logic                 busy;
  logic                 fetch_error;

  modport master (
    input  run, mem_ready, last_word,
    output latch_trigger, update_pc_trigger, fetch_trigger, decode_trigger,
           out_latch_trigger, mem_sel, demux_sel, busy, fetch_error
  );

  modport slave (
    output run, mem_ready, last_word,
    input  latch_trigger, update_pc_trigger, fetch_trigger, decode_trigger,
           out_latch_trigger, mem_sel, demux_sel, busy, fetch_error
  );
endinterface

// File: rtl/fetch_sequencer_param.sv
// Fetch/decode phase sequencer for the multi-word instruction path.
// Per instruction: LATCH -> UPDATE_PC -> up to NUM_WORDS x (FETCH k, DECODE k)
// -> OUT_LATCH. Memory wait states stretch FETCH; last_word ends early.
// Ports:
//   clock  : system clock, all state changes on posedge
//   reset  : synchronous, active-high
//   bus    : fetch_sequencer_param_if.master (controls in, triggers/selects out)
// Optional: define FETCH_TIMEOUT_EN to abort a FETCH that waits TIMEOUT
// cycles; the abort returns to IDLE and sets the sticky fetch_error flag.
// Outputs are Moore: decoded from state, word index and last_idx only.
module fetch_sequencer_param #(
  parameter int NUM_WORDS = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  fetch_sequencer_param_if.master  bus
);
  localparam int SEL_W = $clog2((NUM_WORDS > 2) ? NUM_WORDS : 2);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_WORDS - 1);

  if (NUM_WORDS < 1 || TIMEOUT < 1) begin : g_param_chk
    $error("fetch_sequencer_param: NUM_WORDS and TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_UPDATE_PC, S_FETCH, S_DECODE, S_OUT_LATCH
  } state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] idx, idx_nxt;
  logic [SEL_W-1:0] last_idx, last_idx_nxt;
  logic             timeout_now;  // current wait cycle is the last allowed one
  logic             err_block;    // sticky error holds the sequencer in IDLE

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             fetch_err;

  // Counter is held at 0 outside FETCH, so every FETCH entry starts clean.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state == S_FETCH && !bus.mem_ready) wait_cnt <= wait_cnt + CNT_W'(1);
      else                                    wait_cnt <= '0;
      if (state == S_FETCH && !bus.mem_ready && timeout_now) fetch_err <= 1'b1;
    end
  end

  assign timeout_now     = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign err_block       = fetch_err;
  assign bus.fetch_error = fetch_err;
`else
  assign timeout_now     = 1'b0;
  assign err_block       = 1'b0;
  assign bus.fetch_error = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      last_idx <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      last_idx <= last_idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    last_idx_nxt = last_idx;
    case (state)
      S_IDLE:      if (bus.run && !err_block) state_nxt = S_LATCH;
      S_LATCH:     state_nxt = S_UPDATE_PC;
      S_UPDATE_PC: begin
        state_nxt = S_FETCH;
        idx_nxt   = '0;
      end
      S_FETCH: begin
        if (bus.mem_ready) state_nxt = S_DECODE;
        else if (timeout_now) begin
          state_nxt = S_IDLE;
          idx_nxt   = '0;
        end
      end
      S_DECODE: begin
        if (bus.last_word || idx == LAST_IDX) begin
          state_nxt    = S_OUT_LATCH;
          last_idx_nxt = idx;
        end else begin
          state_nxt = S_FETCH;
          idx_nxt   = idx + SEL_W'(1);
        end
      end
      S_OUT_LATCH: begin
        idx_nxt   = '0;
        state_nxt = bus.run ? S_LATCH : S_IDLE;
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  // One-hot word decode of the current index, shared by fetch and decode.
  logic [NUM_WORDS-1:0] word_oh;
  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    assign word_oh[k] = (idx == SEL_W'(k));
  end

  always_comb begin
    bus.latch_trigger     = 1'b0;
    bus.update_pc_trigger = 1'b0;
    bus.fetch_trigger     = '0;
    bus.decode_trigger    = '0;
    bus.out_latch_trigger = 1'b0;
    bus.mem_sel           = '0;
    bus.demux_sel         = '0;
    bus.busy              = (state != S_IDLE);
    case (state)
      S_LATCH:     bus.latch_trigger     = 1'b1;
      S_UPDATE_PC: bus.update_pc_trigger = 1'b1;
      S_FETCH: begin
        bus.fetch_trigger = word_oh;
        bus.mem_sel       = idx;
      end
      S_DECODE: begin
        bus.decode_trigger = word_oh;
        bus.demux_sel      = idx;
        // Pre-select the next word's address while decoding this one.
        bus.mem_sel        = (idx == LAST_IDX) ? '0 : idx + SEL_W'(1);
      end
      S_OUT_LATCH: begin
        bus.out_latch_trigger = 1'b1;
        bus.demux_sel         = last_idx;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fetch_sequencer_param.sv
module tb_fetch_sequencer_param;
  localparam int IDL = 0, LAT = 1, UPD = 2, FET = 3, DEC = 4, OUT = 5;

  typedef struct packed {
    logic       lat;
    logic       upd;
    logic [2:0] f;
    logic [2:0] d;
    logic       out;
    logic [1:0] ms;
    logic [1:0] ds;
    logic       busy;
    logic       err;
  } out_t;

  typedef struct packed {
    logic run;
    logic mr;
    logic lw;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_sequencer_param_if #(.NUM_WORDS(2)) if2 ();
  fetch_sequencer_param_if #(.NUM_WORDS(3)) if3 ();

  fetch_sequencer_param #(.NUM_WORDS(2), .TIMEOUT(4)) dut2 (
    .clock(clk), .reset(rst), .bus(if2));
  fetch_sequencer_param #(.NUM_WORDS(3), .TIMEOUT(4)) dut3 (
    .clock(clk), .reset(rst), .bus(if3));

  out_t obs2, obs3;
  assign obs2 = '{lat: if2.latch_trigger, upd: if2.update_pc_trigger,
                  f: {1'b0, if2.fetch_trigger}, d: {1'b0, if2.decode_trigger},
                  out: if2.out_latch_trigger, ms: {1'b0, if2.mem_sel},
                  ds: {1'b0, if2.demux_sel}, busy: if2.busy, err: if2.fetch_error};
  assign obs3 = '{lat: if3.latch_trigger, upd: if3.update_pc_trigger,
                  f: if3.fetch_trigger, d: if3.decode_trigger,
                  out: if3.out_latch_trigger, ms: if3.mem_sel,
                  ds: if3.demux_sel, busy: if3.busy, err: if3.fetch_error};

  int n_cmp = 0;
  int n_bad = 0;

  function automatic out_t es(int st, int k, int ms, int ds, logic err = 1'b0);
    out_t o;
    o = '0;
    case (st)
      LAT: o.lat = 1'b1;
      UPD: o.upd = 1'b1;
      FET: o.f[k] = 1'b1;
      DEC: o.d[k] = 1'b1;
      OUT: o.out = 1'b1;
      default: ;
    endcase
    o.ms   = 2'(ms);
    o.ds   = 2'(ds);
    o.busy = (st != IDL);
    o.err  = err;
    return o;
  endfunction

  function automatic vec_t mkv(logic r, logic m, logic l, out_t e);
    vec_t v;
    v.run = r; v.mr = m; v.lw = l; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (lat upd f d out ms ds busy err)",
               name, got, exp);
    end
  endtask

  task automatic step2(input logic r, input logic m, input logic l);
    if2.run = r; if2.mem_ready = m; if2.last_word = l;
    @(posedge clk); #1;
  endtask

  task automatic step3(input logic r, input logic m, input logic l);
    if3.run = r; if3.mem_ready = m; if3.last_word = l;
    @(posedge clk); #1;
  endtask

  vec_t v2[$];
  vec_t v3[$];

  initial begin
    // NUM_WORDS=2: full sequence, back-to-back, wait states, run drop, early end
    v2.push_back(mkv(1,1,0, es(LAT,0,0,0)));
    v2.push_back(mkv(1,1,0, es(UPD,0,0,0)));
    v2.push_back(mkv(1,1,0, es(FET,0,0,0)));
    v2.push_back(mkv(1,1,0, es(DEC,0,1,0)));
    v2.push_back(mkv(1,1,0, es(FET,1,1,0)));
    v2.push_back(mkv(1,1,0, es(DEC,1,0,1)));
    v2.push_back(mkv(1,1,0, es(OUT,0,0,1)));
    v2.push_back(mkv(1,1,0, es(LAT,0,0,0)));
    v2.push_back(mkv(1,1,0, es(UPD,0,0,0)));
    v2.push_back(mkv(1,1,0, es(FET,0,0,0)));
    v2.push_back(mkv(1,1,0, es(DEC,0,1,0)));
    v2.push_back(mkv(1,0,0, es(FET,1,1,0)));
    v2.push_back(mkv(1,0,0, es(FET,1,1,0)));
    v2.push_back(mkv(1,0,0, es(FET,1,1,0)));
    v2.push_back(mkv(1,0,0, es(FET,1,1,0)));
    v2.push_back(mkv(1,1,0, es(DEC,1,0,1)));
    v2.push_back(mkv(1,1,0, es(OUT,0,0,1)));
    v2.push_back(mkv(1,1,0, es(LAT,0,0,0)));
    v2.push_back(mkv(1,1,0, es(UPD,0,0,0)));
    v2.push_back(mkv(1,1,0, es(FET,0,0,0)));
    v2.push_back(mkv(0,1,0, es(DEC,0,1,0)));
    v2.push_back(mkv(0,1,0, es(FET,1,1,0)));
    v2.push_back(mkv(0,1,0, es(DEC,1,0,1)));
    v2.push_back(mkv(0,1,0, es(OUT,0,0,1)));
    v2.push_back(mkv(0,1,0, es(IDL,0,0,0)));
    v2.push_back(mkv(0,1,1, es(IDL,0,0,0)));
    v2.push_back(mkv(1,1,1, es(LAT,0,0,0)));
    v2.push_back(mkv(0,1,1, es(UPD,0,0,0)));
    v2.push_back(mkv(0,1,1, es(FET,0,0,0)));
    v2.push_back(mkv(0,1,1, es(DEC,0,1,0)));
    v2.push_back(mkv(0,1,1, es(OUT,0,0,0)));
    v2.push_back(mkv(0,1,0, es(IDL,0,0,0)));

    // NUM_WORDS=3: early termination at D1, then a full-length instruction
    v3.push_back(mkv(1,1,0, es(LAT,0,0,0)));
    v3.push_back(mkv(1,1,0, es(UPD,0,0,0)));
    v3.push_back(mkv(1,1,0, es(FET,0,0,0)));
    v3.push_back(mkv(1,1,0, es(DEC,0,1,0)));
    v3.push_back(mkv(1,1,0, es(FET,1,1,0)));
    v3.push_back(mkv(1,1,0, es(DEC,1,2,1)));
    v3.push_back(mkv(1,1,1, es(OUT,0,0,1)));
    v3.push_back(mkv(1,1,0, es(LAT,0,0,0)));
    v3.push_back(mkv(1,1,0, es(UPD,0,0,0)));
    v3.push_back(mkv(1,1,0, es(FET,0,0,0)));
    v3.push_back(mkv(1,1,0, es(DEC,0,1,0)));
    v3.push_back(mkv(1,1,0, es(FET,1,1,0)));
    v3.push_back(mkv(1,1,0, es(DEC,1,2,1)));
    v3.push_back(mkv(1,1,0, es(FET,2,2,0)));
    v3.push_back(mkv(1,1,0, es(DEC,2,0,2)));
    v3.push_back(mkv(1,1,0, es(OUT,0,0,2)));
    v3.push_back(mkv(0,1,0, es(IDL,0,0,0)));

    if2.run = 0; if2.mem_ready = 0; if2.last_word = 0;
    if3.run = 0; if3.mem_ready = 0; if3.last_word = 0;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("reset_w2", obs2, es(IDL,0,0,0));
    check("reset_w3", obs3, es(IDL,0,0,0));
    rst = 1'b0;

    foreach (v2[i]) begin
      step2(v2[i].run, v2[i].mr, v2[i].lw);
      check($sformatf("w2_vec%0d", i), obs2, v2[i].exp);
    end
    foreach (v3[i]) begin
      step3(v3[i].run, v3[i].mr, v3[i].lw);
      check($sformatf("w3_vec%0d", i), obs3, v3[i].exp);
    end

    // Reset in the middle of an instruction (dut2 in F1)
    repeat (5) step2(1, 1, 0);
    check("pre_reset_f1", obs2, es(FET,1,1,0));
    rst = 1'b1;
    step2(1, 1, 0);
    check("mid_reset_idle", obs2, es(IDL,0,0,0));
    rst = 1'b0;
    step2(1, 1, 0);
    check("restart_latch", obs2, es(LAT,0,0,0));
    step2(1, 1, 0);
    check("restart_upd", obs2, es(UPD,0,0,0));
    // Drain with a bounded wait; an expired bound shows up as a non-idle compare
    if2.run = 1'b0;
    for (int c = 0; c < 20 && if2.busy; c++) begin
      @(posedge clk); #1;
    end
    check("drain_idle", obs2, es(IDL,0,0,0));

`ifdef FETCH_TIMEOUT_EN
    rst = 1'b1;
    step2(0, 0, 0);
    rst = 1'b0;
    step2(1, 0, 0);
    check("to_lat", obs2, es(LAT,0,0,0));
    step2(1, 0, 0);
    step2(1, 0, 0);
    for (int w = 0; w < 4; w++) begin
      check($sformatf("to_f0_%0d", w), obs2, es(FET,0,0,0));
      step2(1, 0, 0);
    end
    check("to_idle_err", obs2, es(IDL,0,0,0,1'b1));
    step2(1, 1, 0);
    step2(1, 1, 0);
    check("to_run_ignored", obs2, es(IDL,0,0,0,1'b1));
    rst = 1'b1;
    step2(1, 1, 0);
    rst = 1'b0;
    check("to_err_cleared", obs2, es(IDL,0,0,0));
    step2(1, 1, 0);
    check("to_relatch", obs2, es(LAT,0,0,0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fetch_sequencer_param.md
Name: fetch_sequencer_param

Overview:
- Parametrised fetch/decode phase sequencer for the multi-word instruction path.
- Sequence per instruction: latch → PC update → NUM_WORDS × (fetch word k, decode word k) → output latch.
- Adds a run/halt control, memory wait-state extension, and early termination for short instructions.
- Drives the program-memory address mux and the decode-result demux.

Parameters:
- NUM_WORDS, 2, maximum instruction words fetched per instruction (≥1).
- TIMEOUT, 16, wait cycles before fetch error. Used only with FETCH_TIMEOUT_EN; ≥1.
- SEL_W is a localparam, not a parameter: clog2(max(NUM_WORDS,2)).

Ports:
- clock  in  1  system clock; all state changes on the posedge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = start/continue instructions; 0 = halt at the instruction boundary.
- mem_ready  in  1  program memory has valid data for the current fetch.
- last_word  in  1  from the decoder, sampled in DECODE_k: the current word is the final word of the instruction.
- latch_trigger  out  1  input-latch phase.
- update_pc_trigger  out  1  PC-update phase.
- fetch_trigger  out  NUM_WORDS  one-hot; bit k = fetching word k.
- decode_trigger  out  NUM_WORDS  one-hot; bit k = decoding word k.
- out_latch_trigger  out  1  output-latch phase.
- mem_sel  out  SEL_W  program-memory address mux select.
- demux_sel  out  SEL_W  decode demux select.
- busy  out  1  state != IDLE.
- fetch_error  out  1  sticky fetch timeout flag. Tied 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset: synchronous, active-high. Sampled on the posedge and overrides everything, including mid-instruction.
  - State → IDLE; every output → 0; word index → 0; last_idx → 0; wait counter → 0; fetch_error → 0.
- Outputs (Moore): decoded from the state registers and the last_idx register only. No combinational path from any input.
- States: IDLE, LATCH, UPDATE_PC, FETCH(k), DECODE(k), OUT_LATCH.
- Transitions, evaluated on each posedge:
  - IDLE: run=1 → LATCH; otherwise stay.
  - LATCH → UPDATE_PC (unconditional, 1 cycle).
  - UPDATE_PC → FETCH(0).
  - FETCH(k): mem_ready=1 → DECODE(k); otherwise stay in FETCH(k). fetch_trigger[k] is held high for the whole wait.
  - DECODE(k): last_word=1 or k=NUM_WORDS-1 → OUT_LATCH, and last_idx←k; otherwise → FETCH(k+1).
  - OUT_LATCH: run=1 → LATCH (back-to-back instructions, no gap); run=0 → IDLE.
- run is sampled only in IDLE and OUT_LATCH. Deasserting run mid-instruction completes that instruction, then stops.
- last_word is ignored outside DECODE states.
- Output decode, all others 0 in each state:
  - LATCH: latch_trigger=1.
  - UPDATE_PC: update_pc_trigger=1.
  - FETCH(k): fetch_trigger[k]=1, mem_sel=k.
  - DECODE(k): decode_trigger[k]=1, demux_sel=k. mem_sel = k+1 if k<NUM_WORDS-1, else 0 (pre-selects the next address).
  - OUT_LATCH: out_latch_trigger=1, demux_sel=last_idx.
  - IDLE: all 0.
- Exactly one trigger output is high in any non-IDLE state; none in IDLE.
- busy=1 in every state except IDLE.
- Minimum latency: a full-length instruction takes 3+2·NUM_WORDS cycles with mem_ready=1 (7 for NUM_WORDS=2). Each memory wait cycle adds 1.
- NUM_WORDS=1: mem_sel is always 0; DECODE(0) always goes to OUT_LATCH.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - The wait counter clears on entering FETCH(k) and increments each cycle mem_ready=0.
  - When the counter reaches TIMEOUT with mem_ready still 0, the next state is IDLE and fetch_error←1.
  - fetch_error is sticky; cleared only by reset. While fetch_error=1, IDLE ignores run.
- Undefined: no counter logic; FETCH waits indefinitely; fetch_error is constant 0.

Test Plan:
- Reset, then run=1, mem_ready=1, last_word=0, NUM_WORDS=2 → 7-cycle trigger sequence LATCH, UPD, F0, D0, F1, D1, OUT. mem_sel=0,0,0,1,1,0,0; demux_sel=0,0,0,0,0,1,1. run held high → LATCH follows OUT immediately.
- NUM_WORDS=3, last_word=1 during D1 → F0, D0, F1, D1, OUT (F2/D2 skipped); demux_sel=1 in OUT; a second instruction with last_word=0 runs to D2 with demux_sel=2 in OUT.
- mem_ready=0 for 3 cycles in F1 → fetch_trigger=2'b10 held 4 cycles, then D1; total 10 cycles.
- run dropped during D0 → instruction completes through OUT, then IDLE, busy=0, all outputs 0. run reasserted → LATCH on the next posedge.
- reset=1 asserted in F1 → after that posedge: IDLE, all outputs 0, busy=0. Sequence restarts from LATCH when run=1.
- FETCH_TIMEOUT_EN, TIMEOUT=4, mem_ready stuck 0 in F0 → IDLE with fetch_error=1 after 4 wait cycles. run=1 is ignored until reset, then fetch_error=0.
